// File: rtl/stream_serializer.sv
// Parallel-to-serial feeder with valid/ready input and a 1-bit Stream output.
// Optional even-parity bit after each word when STREAM_PARITY_EN is defined.
module stream_serializer #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              Stream,
    output logic              stream_valid,
    output logic              frame_start,
    output logic [CNT_W-1:0]  word_count
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef STREAM_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif

    logic [1:0]        state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  word_count_q, word_count_d;
    logic              last_data;
    logic              word_end;
    logic              accept;
    logic [BIT_W-1:0]  bit_idx;

    always_comb begin
        last_data = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
`ifdef STREAM_PARITY_EN
        word_end  = (state_q == ST_PARITY);
`else
        word_end  = last_data;
`endif
        in_ready  = rst_n && ((state_q == ST_IDLE) || word_end);
        accept    = in_valid && in_ready;

        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        word_count_d = word_count_q;

        if ((state_q == ST_SHIFT) && !last_data) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
        if (word_end) begin
            word_count_d = word_count_q + CNT_W'(1);
        end
`ifdef STREAM_PARITY_EN
        if (last_data) begin
            state_d = ST_PARITY;
        end
`endif
        // A word may be accepted while its predecessor's final cycle is on the wire
        if (word_end || (state_q == ST_IDLE)) begin
            state_d = accept ? ST_SHIFT : ST_IDLE;
        end
        if (accept) begin
            data_d    = in_data;
            bit_cnt_d = '0;
        end
    end

    always_comb begin
        bit_idx = MSB_FIRST ? (LAST_BIT - bit_cnt_q) : bit_cnt_q;
        case (state_q)
            ST_SHIFT:  Stream = data_q[bit_idx];
`ifdef STREAM_PARITY_EN
            ST_PARITY: Stream = ^data_q;
`endif
            default:   Stream = IDLE_LEVEL;
        endcase
        stream_valid = (state_q != ST_IDLE);
        frame_start  = (state_q == ST_SHIFT) && (bit_cnt_q == '0);
        word_count   = word_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            word_count_q <= word_count_d;
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Bench for stream_serializer: an MSB-first/16-bit-count instance and an LSB-first/2-bit-count
// instance share stimulus; a beat-queue model is checked every cycle, plus literal expectations.
module tb_stream_serializer;

`ifdef STREAM_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int W = 8 + (PAR ? 1 : 0);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'h55;
    logic        in_valid = 1'b1;

    logic        rdy_a, s_a, sv_a, fs_a;
    logic [15:0] wc_a;
    logic        rdy_b, s_b, sv_b, fs_b;
    logic [1:0]  wc_b;

    stream_serializer dut_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_a), .Stream(s_a), .stream_valid(sv_a),
        .frame_start(fs_a), .word_count(wc_a)
    );

    stream_serializer #(.MSB_FIRST(1'b0), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_b), .Stream(s_b), .stream_valid(sv_b),
        .frame_start(fs_b), .word_count(wc_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the list of beats still to appear on each Stream, head = current cycle.
    typedef struct packed { logic s; logic fs; logic last; } beat_t;
    beat_t       qa[$];
    beat_t       qb[$];
    logic [15:0] cnt_a = '0;
    logic [1:0]  cnt_b = '0;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                qa.delete(); qb.delete();
                cnt_a = '0; cnt_b = '0;
            end else begin
                bit acc;
                acc = in_valid && (qa.size() <= 1);
                if (qa.size() > 0) begin
                    if (qa[0].last) cnt_a = cnt_a + 16'd1;
                    void'(qa.pop_front());
                end
                if (qb.size() > 0) begin
                    if (qb[0].last) cnt_b = cnt_b + 2'd1;
                    void'(qb.pop_front());
                end
                if (acc) begin
                    for (int i = 0; i < 8; i++) begin
                        qa.push_back('{s: in_data[7-i], fs: (i == 0), last: (i == 7) && !PAR});
                        qb.push_back('{s: in_data[i],   fs: (i == 0), last: (i == 7) && !PAR});
                    end
                    if (PAR) begin
                        qa.push_back('{s: ^in_data, fs: 1'b0, last: 1'b1});
                        qb.push_back('{s: ^in_data, fs: 1'b0, last: 1'b1});
                    end
                end
            end
        end
    end

    // Recorders for literal checks
    logic [63:0] rec_a = '0, rec_b = '0;
    int          rec_n_a = 0, rec_n_b = 0, fs_n_a = 0;
    int          cyc = 0, first_a = 0, last_a = 0;
    logic [1:0]  prev_wc_b = '0;
    logic [1:0]  wc_log[$];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            chk("a_ready", {63'd0, rdy_a}, {63'd0, rst_n && (qa.size() <= 1)});
            chk("b_ready", {63'd0, rdy_b}, {63'd0, rst_n && (qb.size() <= 1)});
            chk("a_stream", {63'd0, s_a}, {63'd0, (qa.size() > 0) ? qa[0].s : 1'b0});
            chk("b_stream", {63'd0, s_b}, {63'd0, (qb.size() > 0) ? qb[0].s : 1'b0});
            chk("a_valid", {63'd0, sv_a}, {63'd0, qa.size() > 0});
            chk("b_valid", {63'd0, sv_b}, {63'd0, qb.size() > 0});
            chk("a_fstart", {63'd0, fs_a}, {63'd0, (qa.size() > 0) ? qa[0].fs : 1'b0});
            chk("b_fstart", {63'd0, fs_b}, {63'd0, (qb.size() > 0) ? qb[0].fs : 1'b0});
            chk("a_count", {48'd0, wc_a}, {48'd0, cnt_a});
            chk("b_count", {62'd0, wc_b}, {62'd0, cnt_b});
            if (sv_a) begin
                if (rec_n_a == 0) first_a = cyc;
                last_a = cyc;
                rec_a = {rec_a[62:0], s_a};
                rec_n_a++;
                if (fs_a) fs_n_a++;
            end
            if (sv_b) begin
                rec_b = {rec_b[62:0], s_b};
                rec_n_b++;
            end
            if (wc_b != prev_wc_b) wc_log.push_back(wc_b);
            prev_wc_b = wc_b;
        end
    end

    logic [7:0] words[$];

    task automatic clr();
        rec_a = '0; rec_b = '0; rec_n_a = 0; rec_n_b = 0; fs_n_a = 0;
    endtask

    task automatic send_all();
        for (int i = 0; i < words.size(); i++) begin
            bit ok;
            in_data  = words[i];
            in_valid = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 40 && !ok; c++) begin
                @(negedge clk);
                if (rdy_a) ok = 1'b1;
            end
            if (!ok) chk("accept_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        words.delete();
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
            @(posedge clk); #1;
            if (!sv_a && !sv_b) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        // 1: reset held with in_valid high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, rdy_a}, 64'd0);
        chk("rst_stream", {63'd0, s_a}, 64'd0);
        chk("rst_count", {48'd0, wc_a}, 64'd0);
        chk("rst_nothing_sent", rec_n_a, 0);
        rst_n = 1'b1; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 2: single word A5
        clr(); words.push_back(8'hA5); send_all(); wait_idle();
        chk("a5_bits_a", rec_a, PAR ? 64'h14A : 64'hA5);
        chk("a5_bits_b", rec_b, PAR ? 64'h14A : 64'hA5);
        chk("a5_len", rec_n_a, W);
        chk("a5_fstarts", fs_n_a, 1);
        chk("a5_count", {48'd0, wc_a}, 64'd1);

        // 3: back-to-back F0, 0F
        clr(); words.push_back(8'hF0); words.push_back(8'h0F); send_all(); wait_idle();
        chk("b2b_bits_a", rec_a, PAR ? 64'h3C01E : 64'hF00F);
        chk("b2b_bits_b", rec_b, PAR ? 64'h3DE0 : 64'h0FF0);
        chk("b2b_len", rec_n_a, 2 * W);
        chk("b2b_gapless", last_a - first_a + 1, rec_n_a);
        chk("b2b_fstarts", fs_n_a, 2);
        chk("b2b_count", {48'd0, wc_a}, 64'd3);

        // 4: LSB-first 01
        clr(); words.push_back(8'h01); send_all(); wait_idle();
        chk("lsb_bits_b", rec_b, PAR ? 64'h101 : 64'h80);
        chk("lsb_bits_a", rec_a, PAR ? 64'h003 : 64'h01);

        // 5: reset after 4th bit of FF
        clr(); words.push_back(8'hFF); send_all();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_stream", {63'd0, s_a}, 64'd0);
        chk("mid_rst_valid", {63'd0, sv_a}, 64'd0);
        chk("mid_rst_count", {48'd0, wc_a}, 64'd0);
        chk("mid_rst_bits", rec_a, 64'hF);
        chk("mid_rst_len", rec_n_a, 4);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        clr(); words.push_back(8'h80); send_all(); wait_idle();
        chk("fresh_bits", rec_a, PAR ? 64'h101 : 64'h80);
        chk("fresh_count", {48'd0, wc_a}, 64'd1);

        // 6: five 07 words, 2-bit counter wraps
        do_reset();
        wc_log.delete();
        clr();
        for (int i = 0; i < 5; i++) words.push_back(8'h07);
        send_all(); wait_idle();
        chk("wrap_len", rec_n_a, 5 * W);
        chk("wrap_log_n", wc_log.size(), 5);
        if (wc_log.size() == 5) begin
            chk("wrap_seq0", {62'd0, wc_log[0]}, 64'd1);
            chk("wrap_seq1", {62'd0, wc_log[1]}, 64'd2);
            chk("wrap_seq2", {62'd0, wc_log[2]}, 64'd3);
            chk("wrap_seq3", {62'd0, wc_log[3]}, 64'd0);
            chk("wrap_seq4", {62'd0, wc_log[4]}, 64'd1);
        end
        chk("wrap_count_a", {48'd0, wc_a}, 64'd5);
        chk("wrap_first_word_a", rec_a[5*W-1 -: 8], 64'h07);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
